// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and types for the CORDIC phase detector
package cordic_pkg;

  // Width of the x/y datapath: 16-bit input plus headroom for the CORDIC gain
  localparam int XY_W = 18;

  // Number of arctangent entries available; ITER may not exceed this
  localparam int ATAN_DEPTH = 16;

  // CORDIC gain 1.64676 in Q16; the magnitude output is not compensated by it
  localparam logic [16:0] CORDIC_GAIN_Q16 = 17'h1A592;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  // round(atan(2^-i) * 2^32 / (2*pi)); entry 0 is the rightmost word
  localparam logic [ATAN_DEPTH-1:0][31:0] ATAN_LUT = {
    32'h0000517D,  // 15
    32'h0000A2FA,  // 14
    32'h000145F3,  // 13
    32'h00028BE6,  // 12
    32'h000517CC,  // 11
    32'h000A2F98,  // 10
    32'h00145F2F,  // 9
    32'h0028BE53,  // 8
    32'h00517C55,  // 7
    32'h00A2F61E,  // 6
    32'h0145D7E1,  // 5
    32'h028B0D43,  // 4
    32'h051111D4,  // 3
    32'h09FB385B,  // 2
    32'h12E4051E,  // 1
    32'h20000000   // 0
  };

endpackage

// File: rtl/cordic_vec_stage.sv
// rtl/cordic_vec_stage.sv - one combinational CORDIC vectoring iteration
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int N = 32
) (
  input  logic signed [XY_W-1:0] x_i,
  input  logic signed [XY_W-1:0] y_i,
  input  logic        [N-1:0]    z_i,
  input  logic        [3:0]      shift_i,
  input  logic        [N-1:0]    atan_i,
  output logic signed [XY_W-1:0] x_o,
  output logic signed [XY_W-1:0] y_o,
  output logic        [N-1:0]    z_o
);

  logic signed [XY_W-1:0] x_sh;
  logic signed [XY_W-1:0] y_sh;

  // Rotate toward y=0; the sign of y picks the direction, both updates use the old x/y
  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (!y_i[XY_W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_phase_det.sv
// rtl/cordic_phase_det.sv - iterative CORDIC phase/magnitude detector (option: CORDIC_FREQ_EST_EN)
module cordic_phase_det
  import cordic_pkg::*;
#(
  parameter int N    = 32,
  parameter int ITER = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [15:0]     sin_in,
  input  logic signed [15:0]     cos_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [N-1:0]    phase_out,
  output logic        [XY_W-1:0] mag_out
`ifdef CORDIC_FREQ_EST_EN
  ,
  output logic        [N-1:0]    freq_out
`endif
);

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_e                 state_q, state_d;
  logic [3:0]             iter_q, iter_d;
  logic signed [XY_W-1:0] x_q, x_d;
  logic signed [XY_W-1:0] y_q, y_d;
  logic [N-1:0]           z_q, z_d;
  // Set when the sample lies on the real axis: the pre-rotation angle is already exact
  logic                   axis_q, axis_d;

  logic signed [XY_W-1:0] cos_ext, sin_ext;
  logic signed [XY_W-1:0] x_nxt, y_nxt;
  logic [N-1:0]           z_nxt;
  logic [N-1:0]           atan_n;

  assign cos_ext = XY_W'(cos_in);
  assign sin_ext = XY_W'(sin_in);
  assign atan_n  = ATAN_LUT[iter_q][31 -: N];

  cordic_vec_stage #(
    .N (N)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (atan_n),
    .x_o     (x_nxt),
    .y_o     (y_nxt),
    .z_o     (z_nxt)
  );

  // Next-state, datapath load/iterate and handshake outputs
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    axis_d    = axis_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          // Fold the left half-plane onto the right so the iterations converge
          if (cos_in[15]) begin
            x_d = -cos_ext;
            y_d = -sin_ext;
            z_d = {1'b1, {(N-1){1'b0}}};
          end else begin
            x_d = cos_ext;
            y_d = sin_ext;
            z_d = '0;
          end
          axis_d  = (sin_in == 16'sd0);
          iter_d  = 4'd0;
          state_d = ROT;
        end
      end
      ROT: begin
        x_d = x_nxt;
        y_d = y_nxt;
        // On the axis the iterations only build the magnitude; the angle stays exact
        if (!axis_q) begin
          z_d = z_nxt;
        end
        if (iter_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any computation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      axis_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      axis_q  <= axis_d;
    end
  end

  assign phase_out = z_q;
  assign mag_out   = x_q;

`ifdef CORDIC_FREQ_EST_EN
  logic [N-1:0] prev_phase_q;
  logic         have_prev_q;

  // Remember the last accepted phase so the next result can report its increment
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase_q <= '0;
      have_prev_q  <= 1'b0;
    end else if (out_valid && out_ready) begin
      prev_phase_q <= z_q;
      have_prev_q  <= 1'b1;
    end
  end

  assign freq_out = have_prev_q ? (z_q - prev_phase_q) : '0;
`endif

endmodule
